trap_controller: RTL and testbench

Machine-mode trap responder that sits after the hazard unit and the CSR file. It accepts an exception (`trapID`) or an `mret` and writes `mepc`/`mcause`/`mtval`/`mstatus` through a handshaked CSR write port, one register per step. It then issues a one-cycle PC redirect to the handler base or to `mepc`. While a sequence is in flight it holds `trap_busy` so the pipeline stays flushed.

---
 rtl/trap_controller_pkg.sv | 26 ++
 rtl/trap_controller_mstatus_update.sv | 29 ++
 rtl/trap_controller.sv | 163 ++++++++++++++++
 tb/tb_trap_controller.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/trap_controller_pkg.sv
// Shared definitions for the machine-mode trap controller.
//   - EXCEPT_* : RISC-V mcause exception codes (shared with the hazard unit).
//                EXCEPT_DO_NOTHING (5'h1F) marks "no exception this cycle".
//   - CSR_*    : machine CSR addresses written by the trap sequence.
//   - MSTATUS_*: bit positions of the mstatus fields that are rewritten.
package trap_controller_pkg;

  localparam logic [4:0] EXCEPT_INST_MISALIGNED  = 5'd0;
  localparam logic [4:0] EXCEPT_ILLEGAL_INST     = 5'd2;
  localparam logic [4:0] EXCEPT_INST_PAGE_FAULT  = 5'd12;
  localparam logic [4:0] EXCEPT_LOAD_PAGE_FAULT  = 5'd13;
  localparam logic [4:0] EXCEPT_STORE_PAGE_FAULT = 5'd15;
  localparam logic [4:0] EXCEPT_DO_NOTHING       = 5'h1F;
  localparam logic [4:0] EXCEPT_NONE             = EXCEPT_DO_NOTHING;

  localparam logic [11:0] CSR_MSTATUS = 12'h300;
  localparam logic [11:0] CSR_MEPC    = 12'h341;
  localparam logic [11:0] CSR_MCAUSE  = 12'h342;
  localparam logic [11:0] CSR_MTVAL   = 12'h343;

  localparam int MSTATUS_MIE    = 3;
  localparam int MSTATUS_MPIE   = 7;
  localparam int MSTATUS_MPP_LO = 11;
  localparam int MSTATUS_MPP_HI = 12;

endpackage

// File: rtl/trap_controller_mstatus_update.sv
// mstatus_update: combinational rewrite of mstatus for trap entry / MRET.
// Ports:
//   mstatus_i  current mstatus value
//   is_mret    1 = MRET (MIE<=MPIE, MPIE<=1), 0 = trap entry (MPIE<=MIE, MIE<=0)
//   mstatus_o  new mstatus; MPP is forced to machine mode (2'b11) in both cases
module trap_controller_mstatus_update
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [XLEN-1:0] mstatus_i,
  input  logic            is_mret,
  output logic [XLEN-1:0] mstatus_o
);

  always_comb begin
    mstatus_o = mstatus_i;
    if (is_mret) begin
      mstatus_o[MSTATUS_MIE]  = mstatus_i[MSTATUS_MPIE];
      mstatus_o[MSTATUS_MPIE] = 1'b1;
    end else begin
      mstatus_o[MSTATUS_MPIE] = mstatus_i[MSTATUS_MIE];
      mstatus_o[MSTATUS_MIE]  = 1'b0;
    end
    // Only machine mode exists, so MPP always records M.
    mstatus_o[MSTATUS_MPP_HI:MSTATUS_MPP_LO] = 2'b11;
  end

endmodule

// File: rtl/trap_controller.sv
// trap_controller: machine-mode trap responder.
// Accepts an exception (trapID) or an MRET while idle, writes the affected
// CSRs one per step through a handshaked write port, then emits a one-cycle
// PC redirect. trap_busy is high whenever a sequence is in flight.
//
// CSR write handshake: csr_we is a request that, once raised, holds with
// csr_waddr/csr_wdata stable until the cycle in which csr_ready is high; the
// write is accepted on that clock edge and the sequence advances.
//
// Ports:
//   clk, rst                     clock, async active-high reset
//   trapID                       exception code, EXCEPT_DO_NOTHING = none
//   trap_pc                      PC of the faulting instruction
//   faulting_inst, faulting_va   mtval sources
//   mret_i                       MRET retiring
//   mtvec_i, mepc_i, mstatus_i   current CSR values
//   csr_we/csr_waddr/csr_wdata   CSR write request, csr_ready = accept
//   redirect_valid/redirect_pc   one-cycle PC redirect
//   trap_busy                    sequence in flight
//   dbg_state                    current FSM state (debug)
module trap_controller
  import trap_controller_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [4:0]      trapID,
  input  logic [XLEN-1:0] trap_pc,
  input  logic [XLEN-1:0] faulting_inst,
  input  logic [XLEN-1:0] faulting_va,
  input  logic            mret_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic [XLEN-1:0] mepc_i,
  input  logic [XLEN-1:0] mstatus_i,
  output logic            csr_we,
  output logic [11:0]     csr_waddr,
  output logic [XLEN-1:0] csr_wdata,
  input  logic            csr_ready,
  output logic            redirect_valid,
  output logic [XLEN-1:0] redirect_pc,
  output logic            trap_busy,
  output logic [2:0]      dbg_state
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    W_EPC   = 3'd1,
    W_CAUSE = 3'd2,
    W_TVAL  = 3'd3,
    W_STAT  = 3'd4,
    M_STAT  = 3'd5,
    REDIR   = 3'd6
  } state_t;

  localparam logic [XLEN-1:0] ALIGN_MASK = ~XLEN'(3);

  state_t          state_q, state_d;
  logic [4:0]      code_q;
  logic [XLEN-1:0] pc_q;      // trap_pc for a trap, aligned mepc for MRET
  logic [XLEN-1:0] tval_q;
  logic            is_mret_q;

  logic            trap_req;
  logic [XLEN-1:0] tval_sel;
  logic [XLEN-1:0] mstatus_new;
  logic            stat_is_mret;

  assign trap_req     = (trapID != EXCEPT_DO_NOTHING);
  assign stat_is_mret = (state_q == M_STAT);

  always_comb begin
    tval_sel = '0;
    case (trapID)
      EXCEPT_INST_MISALIGNED:  tval_sel = trap_pc;
      EXCEPT_ILLEGAL_INST:     tval_sel = faulting_inst;
      EXCEPT_INST_PAGE_FAULT,
      EXCEPT_LOAD_PAGE_FAULT,
      EXCEPT_STORE_PAGE_FAULT: tval_sel = faulting_va;
      default:                 tval_sel = '0;
    endcase
  end

  trap_controller_mstatus_update #(.XLEN(XLEN)) u_mstatus_update (
    .mstatus_i (mstatus_i),
    .is_mret   (stat_is_mret),
    .mstatus_o (mstatus_new)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      code_q    <= '0;
      pc_q      <= '0;
      tval_q    <= '0;
      is_mret_q <= 1'b0;
    end else begin
      state_q <= state_d;
      // Capture only while idle; requests arriving mid-sequence are dropped.
      if (state_q == IDLE) begin
        if (trap_req) begin
          code_q    <= trapID;
          pc_q      <= trap_pc;
          tval_q    <= tval_sel;
          is_mret_q <= 1'b0;
        end else if (mret_i) begin
          pc_q      <= mepc_i & ALIGN_MASK;
          is_mret_q <= 1'b1;
        end
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    csr_we         = 1'b0;
    csr_waddr      = '0;
    csr_wdata      = '0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    case (state_q)
      IDLE: begin
        if (trap_req)    state_d = W_EPC;
        else if (mret_i) state_d = M_STAT;
      end
      W_EPC: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MEPC;
        csr_wdata = pc_q;
        if (csr_ready) state_d = W_CAUSE;
      end
      W_CAUSE: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MCAUSE;
        csr_wdata = {{(XLEN-5){1'b0}}, code_q};
        if (csr_ready) state_d = W_TVAL;
      end
      W_TVAL: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MTVAL;
        csr_wdata = tval_q;
        if (csr_ready) state_d = W_STAT;
      end
      W_STAT, M_STAT: begin
        csr_we    = 1'b1;
        csr_waddr = CSR_MSTATUS;
        csr_wdata = mstatus_new;
        if (csr_ready) state_d = REDIR;
      end
      REDIR: begin
        redirect_valid = 1'b1;
        // Exceptions always enter at BASE, even in vectored mode.
        redirect_pc    = is_mret_q ? pc_q : (mtvec_i & ALIGN_MASK);
        state_d        = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign trap_busy = (state_q != IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_trap_controller.sv
module tb_trap_controller;

  localparam logic [4:0] NO_TRAP = 5'h1F;

  // ---------------- clock / reset ----------------
  logic        clk;
  logic        rst;
  logic [4:0]  trapID;
  logic [31:0] trap_pc, faulting_inst, faulting_va;
  logic        mret_i;
  logic [31:0] mtvec_i, mepc_i, mstatus_i;
  logic        csr_we;
  logic [11:0] csr_waddr;
  logic [31:0] csr_wdata;
  logic        csr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        trap_busy;
  logic [2:0]  dbg_state;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  trap_controller dut (
    .clk            (clk),
    .rst            (rst),
    .trapID         (trapID),
    .trap_pc        (trap_pc),
    .faulting_inst  (faulting_inst),
    .faulting_va    (faulting_va),
    .mret_i         (mret_i),
    .mtvec_i        (mtvec_i),
    .mepc_i         (mepc_i),
    .mstatus_i      (mstatus_i),
    .csr_we         (csr_we),
    .csr_waddr      (csr_waddr),
    .csr_wdata      (csr_wdata),
    .csr_ready      (csr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .trap_busy      (trap_busy),
    .dbg_state      (dbg_state)
  );

  // ---------------- scoreboard ----------------
  // Entry: [47:46] kind (0 fixed data, 1 trap mstatus, 2 mret mstatus),
  //        [43:32] CSR address, [31:0] data for kind 0.
  logic [47:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  function automatic logic [31:0] ref_mstatus(input logic [31:0] m, input bit is_mret);
    if (is_mret) return (m & ~32'h1888) | 32'h1880 | ((m >> 4) & 32'h8);
    return (m & ~32'h1888) | 32'h1800 | ((m & 32'h8) << 4);
  endfunction

  function automatic logic [31:0] ref_tval(input logic [4:0] code, input logic [31:0] pc,
                                           input logic [31:0] inst, input logic [31:0] va);
    case (code)
      5'd0:                 return pc;
      5'd2:                 return inst;
      5'd12, 5'd13, 5'd15:  return va;
      default:              return 32'h0;
    endcase
  endfunction

  // ---------------- driver tasks ----------------
  task automatic drive_junk(input int junk);
    if (junk == 1) begin
      trapID        = 5'($urandom_range(0, 31));
      mret_i        = 1'($urandom_range(0, 1));
      trap_pc       = $urandom;
      faulting_inst = $urandom;
      faulting_va   = $urandom;
      mepc_i        = $urandom;
      mtvec_i       = $urandom;
      mstatus_i     = $urandom;
    end else if (junk == 2) begin
      trapID = 5'd15;
      mret_i = 1'b1;
    end else begin
      trapID = NO_TRAP;
      mret_i = 1'b0;
    end
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      chk("idle_busy", trap_busy, 0);
      chk("idle_redirect", redirect_valid, 0);
      @(posedge clk); #1;
    end
  endtask

  // Called 1 time unit after a rising edge in an idle cycle ("cycle 0").
  // st holds the planned number of stall cycles before each write, 4 bits each.
  task automatic run_seq(input logic [4:0] code, input logic mret,
                         input logic [31:0] pc, input logic [31:0] inst,
                         input logic [31:0] va, input logic [31:0] mepc,
                         input logic [31:0] mtvec, input logic [31:0] mstat,
                         input int junk, input logic [15:0] st);
    int          sched[40];
    int          c, r, n;
    bit          is_trap;
    logic [31:0] ret_pc, exp_d;
    logic [47:0] e;

    trapID = code; mret_i = mret; trap_pc = pc; faulting_inst = inst;
    faulting_va = va; mepc_i = mepc; mtvec_i = mtvec; mstatus_i = mstat;

    is_trap = (code != NO_TRAP);
    ret_pc  = mepc & 32'hFFFF_FFFC;
    exp_q.delete();
    if (is_trap) begin
      exp_q.push_back({2'd0, 2'd0, 12'h341, pc});
      exp_q.push_back({2'd0, 2'd0, 12'h342, {27'b0, code}});
      exp_q.push_back({2'd0, 2'd0, 12'h343, ref_tval(code, pc, inst, va)});
      exp_q.push_back({2'd1, 2'd0, 12'h300, 32'h0});
      n = 4;
    end else begin
      exp_q.push_back({2'd2, 2'd0, 12'h300, 32'h0});
      n = 1;
    end

    foreach (sched[i]) sched[i] = int'($urandom_range(0, 1));
    c = 1;
    for (int i = 0; i < n; i++) begin
      for (int k = 0; k < int'(st[4*i +: 4]); k++) begin
        sched[c] = 0;
        c++;
      end
      sched[c] = 1;
      c++;
    end
    r = c;  // cycle in which the redirect pulse is due

    // Nothing may react to the request before the capturing edge.
    @(negedge clk);
    chk("pre_busy", trap_busy, 0);
    chk("pre_we", csr_we, 0);
    chk("pre_redirect", redirect_valid, 0);
    @(posedge clk); #1;
    csr_ready = sched[1][0];
    drive_junk(junk);

    for (int cyc = 1; cyc <= r; cyc++) begin
      @(negedge clk);
      if (cyc < r) begin
        chk("busy", trap_busy, 1);
        chk("early_redirect", redirect_valid, 0);
        chk("csr_we", csr_we, 1);
        if (exp_q.size() > 0) begin
          e = exp_q[0];
          exp_d = (e[47:46] == 2'd0) ? e[31:0] : ref_mstatus(mstatus_i, e[47:46] == 2'd2);
          chk("csr_waddr", csr_waddr, e[43:32]);
          chk("csr_wdata", csr_wdata, exp_d);
          if (sched[cyc] == 1) void'(exp_q.pop_front());
        end else begin
          chk("extra_write", 1, 0);
        end
      end else begin
        chk("redirect_valid", redirect_valid, 1);
        chk("redirect_pc", redirect_pc, is_trap ? (mtvec_i & 32'hFFFF_FFFC) : ret_pc);
        chk("redir_busy", trap_busy, 1);
        chk("redir_we", csr_we, 0);
        chk("writes_left", exp_q.size(), 0);
      end
      @(posedge clk); #1;
      if (cyc < r) begin
        csr_ready = sched[cyc + 1][0];
        drive_junk(junk);
      end else begin
        drive_junk(0);
      end
    end
  endtask

  task automatic reset_mid_sequence();
    trapID = 5'd5; mret_i = 1'b0; csr_ready = 1'b1;
    @(posedge clk); #1;             // cycle 1: W_EPC
    trapID = NO_TRAP;
    @(posedge clk); #1;             // cycle 2: W_CAUSE
    @(negedge clk);
    chk("rst_pre_busy", trap_busy, 1);
    #2 rst = 1'b1;
    #1;
    chk("rst_we", csr_we, 0);
    chk("rst_busy", trap_busy, 0);
    chk("rst_redirect", redirect_valid, 0);
    chk("rst_state", dbg_state, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_rst_redirect", redirect_valid, 0);
      chk("post_rst_busy", trap_busy, 0);
      chk("post_rst_we", csr_we, 0);
      @(posedge clk); #1;
    end
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [4:0]  code;
    logic        mret;
    logic [15:0] st;

    rst = 1'b1; trapID = NO_TRAP; mret_i = 1'b0; csr_ready = 1'b0;
    trap_pc = '0; faulting_inst = '0; faulting_va = '0;
    mtvec_i = '0; mepc_i = '0; mstatus_i = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_we", csr_we, 0);
    chk("reset_waddr", csr_waddr, 0);
    chk("reset_wdata", csr_wdata, 0);
    chk("reset_redirect_valid", redirect_valid, 0);
    chk("reset_redirect_pc", redirect_pc, 0);
    chk("reset_busy", trap_busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    idle_cycles(2);

    // Illegal instruction, ready tied high: redirect in cycle 5.
    run_seq(5'd2, 1'b0, 32'h8000_0010, 32'hFFFF_FFFF, 32'h0, 32'h0,
            32'h8000_0101, 32'h0000_0008, 0, 16'h0000);
    // Load page fault with three stalls in W_CAUSE: redirect in cycle 8.
    run_seq(5'd13, 1'b0, 32'h8000_0200, 32'h1234_5678, 32'hDEAD_BEE0, 32'h0,
            32'h8000_0000, 32'h0000_1800, 0, 16'h0030);
    // MRET: mstatus 0x1880 -> 0x1888, redirect to aligned mepc in cycle 2.
    run_seq(NO_TRAP, 1'b1, 32'h0, 32'h0, 32'h0, 32'h8000_0402,
            32'h8000_0000, 32'h0000_1880, 0, 16'h0000);
    // Simultaneous trap and MRET: trap wins.
    run_seq(5'd13, 1'b1, 32'h8000_0300, 32'h0, 32'h0000_4000, 32'h8000_0804,
            32'h0000_1000, 32'h0000_0088, 0, 16'h0000);
    // Trap 15 / MRET held throughout the sequence: ignored.
    run_seq(5'd12, 1'b0, 32'h8000_0400, 32'h0, 32'hC000_0000, 32'h0,
            32'h0000_2003, 32'h0000_0000, 2, 16'h0100);
    idle_cycles(1);
    // Asynchronous reset in the middle of a sequence.
    reset_mid_sequence();
    run_seq(5'd0, 1'b0, 32'h8000_0002, 32'h0, 32'h0, 32'h0,
            32'h8000_0100, 32'hFFFF_FFFF, 0, 16'h0000);

    // Randomized transactions, back-to-back or separated by idle cycles.
    for (int t = 0; t < 40; t++) begin
      code = 5'($urandom_range(0, 31));
      mret = (code == NO_TRAP) ? 1'b1 : 1'($urandom_range(0, 1));
      st = '0;
      for (int i = 0; i < 4; i++)
        if ($urandom_range(0, 1) == 1) st[4*i +: 4] = 4'($urandom_range(1, 3));
      run_seq(code, mret, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom,
              int'($urandom_range(0, 1)), st);
      if ($urandom_range(0, 2) == 0) idle_cycles(int'($urandom_range(1, 3)));
    end

    drive_junk(0);
    idle_cycles(3);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
